// File: rtl/gpio_v2_pkg.sv
// Shared constants for the second-generation GPIO core: register offsets,
// interrupt-mode encoding and default parameter values.
package gpio_v2_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned DATA_W = 32;

  localparam int unsigned PIN_NUM_DEF     = 8;
  localparam int unsigned SYNC_STAGES_DEF = 2;
  localparam int unsigned DB_CNT_W_DEF    = 8;

  localparam logic [ADDR_W-1:0] ADDR_DIR       = 6'h00;
  localparam logic [ADDR_W-1:0] ADDR_IN        = 6'h04;
  localparam logic [ADDR_W-1:0] ADDR_OUT       = 6'h08;
  localparam logic [ADDR_W-1:0] ADDR_INTEN     = 6'h0C;
  localparam logic [ADDR_W-1:0] ADDR_INTTYPE0  = 6'h10;
  localparam logic [ADDR_W-1:0] ADDR_INTTYPE1  = 6'h14;
  localparam logic [ADDR_W-1:0] ADDR_INTSTATUS = 6'h18;
  localparam logic [ADDR_W-1:0] ADDR_IOFCFG    = 6'h1C;
  localparam logic [ADDR_W-1:0] ADDR_OUTSET    = 6'h20;
  localparam logic [ADDR_W-1:0] ADDR_OUTCLR    = 6'h24;
  localparam logic [ADDR_W-1:0] ADDR_DBTHR     = 6'h28;

  // Encoded as {INTTYPE1, INTTYPE0}
  typedef enum logic [1:0] {
    RISE = 2'b00,
    FALL = 2'b01,
    HIGH = 2'b10,
    LOW  = 2'b11
  } irq_mode_e;

endpackage

// File: rtl/gpio_core_v2_if.sv
// Register-port bundle between the APB4 bridge (master) and the GPIO core (slave).
interface gpio_core_v2_if;
  import gpio_v2_pkg::*;

  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic [DATA_W-1:0] rdata_o;

  modport master (output req_i, output we_i, output addr_i, output wdata_i, input rdata_o);
  modport slave  (input req_i, input we_i, input addr_i, input wdata_i, output rdata_o);
endinterface

// File: rtl/gpio_v2_pin_filter.sv
// One pin's input path: synchroniser, debounce filter and interrupt condition.
module gpio_v2_pin_filter
  import gpio_v2_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CNT_W    = DB_CNT_W_DEF
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  input  logic                i_pad,
  input  logic [DB_CNT_W-1:0] i_thr,
  input  irq_mode_e           i_mode,
  output logic                o_filt_c,
  output logic                o_cond_c
);

  localparam int unsigned CW = DB_CNT_W + 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic [DB_CNT_W-1:0]    r_cnt;
  logic                   r_filt;
  logic                   r_prev;
  logic                   w_sync;
  logic                   w_bypass;
  logic                   w_reach;

  assign w_sync   = r_sync[SYNC_STAGES-1];
  assign w_bypass = (i_thr == '0);
  assign w_reach  = ({1'b0, r_cnt} + CW'(1)) >= {1'b0, i_thr};
  assign o_filt_c = w_bypass ? w_sync : r_filt;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_sync <= '0;
      r_cnt  <= '0;
      r_filt <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pad};
      r_prev <= o_filt_c;
      // Bypass keeps r_filt tracking so re-enabling the filter starts clean
      if (w_bypass || (w_sync == r_filt)) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else if (w_reach) begin
        r_filt <= w_sync;
        r_cnt  <= '0;
      end else begin
        r_cnt  <= r_cnt + DB_CNT_W'(1);
      end
    end
  end

  always_comb begin
    o_cond_c = 1'b0;
    case (i_mode)
      RISE:    o_cond_c =  o_filt_c & ~r_prev;
      FALL:    o_cond_c = ~o_filt_c &  r_prev;
      HIGH:    o_cond_c =  o_filt_c;
      LOW:     o_cond_c = ~o_filt_c;
      default: o_cond_c = 1'b0;
    endcase
  end

endmodule

// File: rtl/gpio_core_v2.sv
// GPIO core top: register file, atomic OUT set/clear, W1C interrupt status
// and registered read mux over PIN_NUM per-pin input filters.
module gpio_core_v2
  import gpio_v2_pkg::*;
#(
  parameter int unsigned PIN_NUM     = PIN_NUM_DEF,
  parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int unsigned DB_CNT_W    = DB_CNT_W_DEF
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  gpio_core_v2_if.slave      reg_bus,
  input  logic [PIN_NUM-1:0] gpio_in_i,
  output logic [PIN_NUM-1:0] gpio_out_o,
  output logic [PIN_NUM-1:0] gpio_dir_o,
  output logic [PIN_NUM-1:0] gpio_iof_o,
  output logic               irq_o
);

  logic [PIN_NUM-1:0]  r_dir, r_out, r_inten, r_type0, r_type1, r_status, r_iof;
  logic [DB_CNT_W-1:0] r_dbthr;
  logic [DATA_W-1:0]   r_rdata;

  logic [ADDR_W-1:0]   w_addr;
  logic                w_wr, w_rd;
  logic [PIN_NUM-1:0]  w_wpins, w_filt, w_cond, w_clr;
  logic [DATA_W-1:0]   w_rdata;
  logic                w_unused;

  assign w_addr   = {reg_bus.addr_i[ADDR_W-1:2], 2'b00};
  assign w_wr     = reg_bus.req_i &  reg_bus.we_i;
  assign w_rd     = reg_bus.req_i & ~reg_bus.we_i;
  assign w_wpins  = reg_bus.wdata_i[PIN_NUM-1:0];
  assign w_clr    = (w_wr && (w_addr == ADDR_INTSTATUS)) ? w_wpins : '0;
  assign w_unused = &{1'b0, reg_bus.addr_i[1:0], reg_bus.wdata_i};

  for (genvar i = 0; i < int'(PIN_NUM); i++) begin : g_pin
    gpio_v2_pin_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .DB_CNT_W    (DB_CNT_W)
    ) u_filt (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .i_pad    (gpio_in_i[i]),
      .i_thr    (r_dbthr),
      .i_mode   (irq_mode_e'({r_type1[i], r_type0[i]})),
      .o_filt_c (w_filt[i]),
      .o_cond_c (w_cond[i])
    );
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_dir   <= '0;
      r_out   <= '0;
      r_inten <= '0;
      r_type0 <= '0;
      r_type1 <= '0;
      r_iof   <= '0;
      r_dbthr <= '0;
    end else if (w_wr) begin
      case (w_addr)
        ADDR_DIR:      r_dir   <= w_wpins;
        ADDR_OUT:      r_out   <= w_wpins;
        ADDR_INTEN:    r_inten <= w_wpins;
        ADDR_INTTYPE0: r_type0 <= w_wpins;
        ADDR_INTTYPE1: r_type1 <= w_wpins;
        ADDR_IOFCFG:   r_iof   <= w_wpins;
        ADDR_OUTSET:   r_out   <= r_out | w_wpins;
        ADDR_OUTCLR:   r_out   <= r_out & ~w_wpins;
        ADDR_DBTHR:    r_dbthr <= reg_bus.wdata_i[DB_CNT_W-1:0];
        default:       ;
      endcase
    end
  end

  // New events take priority over a same-cycle W1C
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) r_status <= '0;
    else          r_status <= (w_cond & r_inten) | (r_status & ~w_clr);
  end

  always_comb begin
    w_rdata = '0;
    case (w_addr)
      ADDR_DIR:       w_rdata = DATA_W'(r_dir);
      ADDR_IN:        w_rdata = DATA_W'(w_filt);
      ADDR_OUT:       w_rdata = DATA_W'(r_out);
      ADDR_INTEN:     w_rdata = DATA_W'(r_inten);
      ADDR_INTTYPE0:  w_rdata = DATA_W'(r_type0);
      ADDR_INTTYPE1:  w_rdata = DATA_W'(r_type1);
      ADDR_INTSTATUS: w_rdata = DATA_W'(r_status);
      ADDR_IOFCFG:    w_rdata = DATA_W'(r_iof);
      ADDR_DBTHR:     w_rdata = DATA_W'(r_dbthr);
      default:        w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i)  r_rdata <= '0;
    else if (w_rd) r_rdata <= w_rdata;
  end

  assign reg_bus.rdata_o = r_rdata;
  assign gpio_out_o      = r_out;
  assign gpio_dir_o      = r_dir;
  assign gpio_iof_o      = r_iof;
  assign irq_o           = |r_status;

endmodule

// File: tb/tb_gpio_core_v2.sv
// Directed bench for gpio_core_v2 (PIN_NUM=8, SYNC_STAGES=2, DB_CNT_W=8).
module tb_gpio_core_v2;
  import gpio_v2_pkg::*;

  logic       clk;
  logic       rst_n;
  logic [7:0] gpio_in;
  logic [7:0] gpio_out, gpio_dir, gpio_iof;
  logic       irq;
  int         n_cmp;
  int         n_err;
  logic [31:0] d;

  gpio_core_v2_if bus ();

  gpio_core_v2 #(.PIN_NUM(8), .SYNC_STAGES(2), .DB_CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .reg_bus    (bus),
    .gpio_in_i  (gpio_in),
    .gpio_out_o (gpio_out),
    .gpio_dir_o (gpio_dir),
    .gpio_iof_o (gpio_iof),
    .irq_o      (irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic reg_wr(input logic [5:0] a, input logic [31:0] v);
    bus.req_i   = 1'b1;
    bus.we_i    = 1'b1;
    bus.addr_i  = a;
    bus.wdata_i = v;
    cycles(1);
    bus.req_i   = 1'b0;
    bus.we_i    = 1'b0;
  endtask

  task automatic reg_rd(input logic [5:0] a, output logic [31:0] v);
    bus.req_i  = 1'b1;
    bus.we_i   = 1'b0;
    bus.addr_i = a;
    cycles(1);
    bus.req_i  = 1'b0;
    v = bus.rdata_o;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    gpio_in = '0;
    bus.req_i = 1'b0;
    bus.we_i = 1'b0;
    bus.addr_i = '0;
    bus.wdata_i = '0;
    cycles(3);
    rst_n = 1'b1;
    cycles(1);

    // Reset state
    check("rst_irq", 32'(irq), 32'h0);
    check("rst_out", 32'(gpio_out), 32'h0);
    check("rst_rdata", bus.rdata_o, 32'h0);
    for (int a = 0; a <= 'h28; a += 4) begin
      reg_rd(6'(a), d);
      check($sformatf("rst_rd_%02h", a), d, 32'h0);
    end

    // DIR width masking, unmapped/write-only reads
    reg_wr(ADDR_DIR, 32'hFFFF_FFFF);
    check("dir_out", 32'(gpio_dir), 32'h0000_00FF);
    reg_rd(ADDR_DIR, d);
    check("dir_rd", d, 32'h0000_00FF);
    reg_wr(6'h2C, 32'h0000_0000);
    reg_rd(ADDR_DIR, d);
    check("unmapped_wr", d, 32'h0000_00FF);
    cycles(2);
    check("rdata_hold", bus.rdata_o, 32'h0000_00FF);
    reg_rd(6'h2C, d);
    check("unmapped_rd", d, 32'h0);
    reg_wr(ADDR_IOFCFG, 32'h0000_01A5);
    check("iof_out", 32'(gpio_iof), 32'h0000_00A5);

    // Atomic set/clear
    reg_wr(ADDR_OUT, 32'h0F);
    reg_wr(ADDR_OUTSET, 32'h30);
    check("outset", 32'(gpio_out), 32'h3F);
    reg_wr(ADDR_OUTCLR, 32'h03);
    check("outclr", 32'(gpio_out), 32'h3C);
    reg_rd(ADDR_OUTSET, d);
    check("outset_rd", d, 32'h0);
    reg_rd(ADDR_OUT, d);
    check("out_rd", d, 32'h3C);

    // Debounce: 3-cycle glitch rejected
    reg_wr(ADDR_DBTHR, 32'h4);
    reg_rd(ADDR_DBTHR, d);
    check("dbthr_rd", d, 32'h4);
    gpio_in[0] = 1'b1;
    cycles(3);
    gpio_in[0] = 1'b0;
    cycles(8);
    reg_rd(ADDR_IN, d);
    check("glitch_in", d, 32'h0);

    // Debounce: stable pulse reaches IN after SYNC_STAGES + 4 cycles
    gpio_in[0] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      reg_rd(ADDR_IN, d);
      check($sformatf("lat_rd%0d", i), d, (i >= 7) ? 32'h1 : 32'h0);
    end
    gpio_in[0] = 1'b0;
    cycles(12);
    reg_rd(ADDR_IN, d);
    check("pulse_end_in", d, 32'h0);

    // Pin 2 rising edge, W1C clears and stays clear
    reg_wr(ADDR_DBTHR, 32'h0);
    reg_wr(ADDR_INTEN, 32'h04);
    gpio_in[2] = 1'b1;
    cycles(4);
    check("rise_irq", 32'(irq), 32'h1);
    reg_rd(ADDR_INTSTATUS, d);
    check("rise_st", d, 32'h04);
    reg_wr(ADDR_INTSTATUS, 32'h04);
    check("rise_w1c_irq", 32'(irq), 32'h0);
    cycles(3);
    reg_rd(ADDR_INTSTATUS, d);
    check("rise_hold_st", d, 32'h0);

    // Pin 5 high level: W1C ineffective while level persists
    reg_wr(ADDR_INTTYPE1, 32'h20);
    reg_wr(ADDR_INTEN, 32'h24);
    gpio_in[5] = 1'b1;
    cycles(4);
    reg_rd(ADDR_INTSTATUS, d);
    check("lvl_st", d, 32'h20);
    reg_wr(ADDR_INTSTATUS, 32'h20);
    reg_rd(ADDR_INTSTATUS, d);
    check("lvl_w1c_st", d, 32'h20);
    check("lvl_irq", 32'(irq), 32'h1);
    gpio_in[5] = 1'b0;
    cycles(4);
    reg_wr(ADDR_INTSTATUS, 32'h20);
    reg_rd(ADDR_INTSTATUS, d);
    check("lvl_clr_st", d, 32'h0);
    check("lvl_clr_irq", 32'(irq), 32'h0);

    // Pin 3 falling edge coincident with W1C: set wins
    gpio_in[3] = 1'b1;
    cycles(4);
    reg_wr(ADDR_INTTYPE0, 32'h08);
    reg_wr(ADDR_INTEN, 32'h2C);
    reg_rd(ADDR_INTSTATUS, d);
    check("fall_pre_st", d, 32'h0);
    gpio_in[3] = 1'b0;
    cycles(2);
    reg_wr(ADDR_INTSTATUS, 32'h08);
    reg_rd(ADDR_INTSTATUS, d);
    check("fall_race_st", d, 32'h08);
    check("fall_race_irq", 32'(irq), 32'h1);
    reg_wr(ADDR_INTSTATUS, 32'h08);
    reg_rd(ADDR_INTSTATUS, d);
    check("fall_clr_st", d, 32'h0);

    // Reset mid-debounce
    reg_wr(ADDR_DBTHR, 32'h4);
    gpio_in[5] = 1'b1;
    cycles(8);
    check("pre_rst_irq", 32'(irq), 32'h1);
    gpio_in[0] = 1'b1;
    cycles(4);
    check("pre_rst_cnt", 32'(dut.g_pin[0].u_filt.r_cnt), 32'h2);
    rst_n = 1'b0;
    gpio_in = '0;
    #1;
    check("rst_async_irq", 32'(irq), 32'h0);
    check("rst_async_cnt", 32'(dut.g_pin[0].u_filt.r_cnt), 32'h0);
    check("rst_async_out", 32'(gpio_out), 32'h0);
    check("rst_async_rdata", bus.rdata_o, 32'h0);
    cycles(2);
    rst_n = 1'b1;
    cycles(1);
    reg_rd(ADDR_IN, d);
    check("post_rst_in", d, 32'h0);
    reg_rd(ADDR_DBTHR, d);
    check("post_rst_dbthr", d, 32'h0);
    reg_rd(ADDR_INTSTATUS, d);
    check("post_rst_st", d, 32'h0);
    check("post_rst_irq", 32'(irq), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/gpio_core_v2.md
# gpio_core_v2

Parametrised second-generation GPIO core: per-pin direction, output, IO-function select and interrupt logic for `PIN_NUM` pins. It adds an input synchroniser, a programmable debounce filter, four interrupt modes, W1C status, and atomic output set/clear. It sits behind the APB4 bridge on a simple register port and drives the pad ring through the existing `gpio_if` signal set.

## Interface
- `PIN_NUM`, 8: pin count, 1..32.
- `SYNC_STAGES`, 2: input synchroniser depth, ≥2.
- `DB_CNT_W`, 8: debounce counter/threshold width.
- `clk_i` input 1: core clock.
- `rst_n_i` input 1: asynchronous, active-low reset.
- `req_i` input 1: register access strobe, one cycle per access.
- `we_i` input 1: 1 = write, 0 = read.
- `addr_i` input 6: byte address; bits [1:0] ignored.
- `wdata_i` input 32: write data.
- `rdata_o` output 32: read data, registered.
- `gpio_in_i` input PIN_NUM: raw pad inputs, asynchronous.
- `gpio_out_o` output PIN_NUM: OUT register.
- `gpio_dir_o` output PIN_NUM: DIR register, 1 = output.
- `gpio_iof_o` output PIN_NUM: IOFCFG register.
- `irq_o` output 1: OR of INTSTATUS.

## Operation
- Register map (byte offset, access): DIR 0x00 RW; IN 0x04 R (filtered inputs); OUT 0x08 RW; INTEN 0x0C RW; INTTYPE0 0x10 RW; INTTYPE1 0x14 RW; INTSTATUS 0x18 R/W1C; IOFCFG 0x1C RW; OUTSET 0x20 W (OUT |= wdata); OUTCLR 0x24 W (OUT &= ~wdata); DBTHR 0x28 RW, bits [DB_CNT_W-1:0].
- Bits ≥ PIN_NUM read 0 and ignore writes. Unmapped addresses read 0 and ignore writes. Write-only registers read 0.
- Input path:
  - `gpio_in_i` passes through a SYNC_STAGES flop chain.
  - Debounce: each pin has a counter. It counts while the synchronised value differs from the filtered value, and resets to 0 when they match.
  - When the count reaches DBTHR, the filtered value takes the synchronised value and the counter clears.
  - DBTHR = 0 bypasses the filter: filtered = synchronised.
- Interrupt mode per pin, as {INTTYPE1, INTTYPE0}: 00 rising edge, 01 falling edge, 10 high level, 11 low level. Edges are detected on the filtered value against its previous-cycle copy.
- INTSTATUS bit:
  - Sets when INTEN=1 and the condition is true.
  - Clears when written 1 at INTSTATUS.
  - If set and clear occur in the same cycle, set wins.
  - A level condition that is still true re-sets the bit immediately, so W1C has no visible effect until the level goes away.
  - Clearing INTEN does not clear pending status.
- `irq_o` = |INTSTATUS, driven directly from the status flops.

## Timing
- Reset values: all registers 0; DBTHR = 0 (bypass); synchroniser, filtered value and counters 0; `rdata_o` = 0; `irq_o` = 0. Reset is effective mid-operation, with no pending event preserved.
- A write on cycle N takes effect on the outputs at N+1.
- A read on cycle N presents `rdata_o` at N+1. `rdata_o` holds its value until the next read.
- Pad to IN latency: SYNC_STAGES cycles plus DBTHR cycles of stable input (filter update after DBTHR consecutive mismatching cycles).
- Filtered edge to INTSTATUS/`irq_o` is one cycle.
- An input glitch shorter than DBTHR cycles never reaches IN.

## Structure
- Package `gpio_v2_pkg`: register offset constants, the interrupt-mode enum (`RISE`, `FALL`, `HIGH`, `LOW`), and the default parameter values.
- Sub-module `gpio_v2_pin_filter`: one pin's synchroniser, debounce counter and edge/level detector, generated PIN_NUM times.
- Top level: the register file and read mux.

## Test plan
- Reset, then read every register → all 0, `irq_o` = 0. Write DIR = 0xFFFF_FFFF with PIN_NUM = 8 → reads 0xFF, `gpio_dir_o` = 0xFF.
- OUT = 0x0F, write OUTSET 0x30 → OUT = 0x3F. Write OUTCLR 0x03 → OUT = 0x3C. Each result is visible the cycle after the write.
- DBTHR = 4: a 3-cycle high pulse on pin 0 → IN stays 0. A 6-cycle pulse → IN[0] = 1 exactly SYNC_STAGES + 4 cycles after the rising edge.
- Pin 2 rising-edge mode with INTEN[2] = 1: pad rises → INTSTATUS = 0x04 and `irq_o` = 1. Write 0x04 to INTSTATUS → both clear; the pin staying high does not re-set them.
- Pin 5 high-level mode: pad held high, W1C 0x20 → INTSTATUS stays 0x20. Pad low, then W1C → status clears.
- Falling-edge event coincides with a W1C of the same bit → status remains 1. Assert `rst_n_i` mid-debounce → counter, IN and `irq_o` all return to 0.
